alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width of A, B, PC, IMM and ALUout.
REQ-002 Parameter MUL_LAT, default 3: cycles a MUL result occupies the unit, legal range 1..15.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port in_valid, input, 1: operand bundle valid.
REQ-006 Port in_ready, output, 1: unit accepts a bundle this cycle.
REQ-007 Port A, B, PC, IMM, each input, XLEN: operands, program counter, sign-extended immediate.
REQ-008 Port IR, input, 32: instruction; opcode is IR[31:26], jump offset is IR[25:0].
REQ-009 Port type, input, 3: class; 000 RR_ALU, 001 RI_ALU, 100 BRANCH, 101 JUMP, 111 NOP.
REQ-010 Port out_valid, output, 1: result valid.
REQ-011 Port out_ready, input, 1: consumer accepts the result.
REQ-012 Port ALUout, output, XLEN: registered result or target address.
REQ-013 Port br_taken, output, 1: branch/jump taken, valid with out_valid.
REQ-014 Port illegal, output, 1: opcode not defined for the given type, valid with out_valid.

Function
REQ-015 The unit SHALL accept a bundle on the cycle where in_valid and in_ready are both high.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-017 The FSM SHALL have three states: IDLE, MUL_BUSY and HOLD.
- IDLE + accepted MUL with MUL_LAT>1 -> MUL_BUSY.
- IDLE + any other accepted op -> result registered next edge, stays IDLE.
- MUL_BUSY counts down MUL_LAT-1 cycles, then registers the result.
REQ-018 Non-MUL latency SHALL be 1 cycle (accept edge N, out_valid high after edge N); MUL latency SHALL be MUL_LAT cycles.
REQ-019 out_valid with ALUout, br_taken and illegal SHALL hold stable until out_valid && out_ready; with no new result that edge, out_valid SHALL clear.
REQ-020 With out_valid && out_ready and an accepted non-MUL bundle on the same edge, the new result SHALL replace the old one with no bubble.
REQ-021 RR_ALU opcodes SHALL compute:
- ADD 000000: A+B; SUB 000001: A-B; MUL 000010: low XLEN bits of A*B.
- AND 000011, OR 000100, XOR 000101: bitwise.
- SLL 000110 / SRL 000111: logical shift of A by B[$clog2(XLEN)-1:0].
REQ-022 RI_ALU opcodes SHALL compute: ADDI 001000 A+IMM; SUBI 001001 A-IMM; ANDI 001010; ORI 001011; XORI 001100.
REQ-023 BRANCH SHALL produce ALUout = PC+IMM mod 2^XLEN, with br_taken as follows:
- BEQ 011000: A==B; BNE 011001: A!=B.
- BLT 011010: signed A<B; BGE 011011: signed A>=B.
REQ-024 JUMP SHALL produce ALUout = PC + zero-extended IR[25:0] mod 2^XLEN, with br_taken=1.
REQ-025 NOP type, and any undefined type, SHALL produce ALUout=0, br_taken=0, illegal=0.
REQ-026 An undefined opcode within RR_ALU, RI_ALU or BRANCH SHALL produce ALUout=0, br_taken=0, illegal=1 and SHALL still complete a handshake.
REQ-027 All arithmetic SHALL wrap mod 2^XLEN; no carry or overflow output exists.
REQ-028 Operands SHALL be captured at acceptance; input changes during MUL_BUSY SHALL NOT affect the result.

Reset
REQ-029 While rst is high: state=IDLE, MUL counter=0, out_valid=0, ALUout=0, br_taken=0, illegal=0, in_ready=0.
REQ-030 rst asserted mid-MUL SHALL abort the operation; no result SHALL appear after rst deasserts.
REQ-031 On the first edge after rst deasserts, in_ready SHALL be 1.

Verification
REQ-032 The bench SHALL cover: RR ADD A=32'hFFFFFFFF, B=1, out_ready=1 -> one cycle later ALUout=0, out_valid=1, illegal=0.
REQ-033 The bench SHALL cover: MUL A=7, B=6, MUL_LAT=3 -> in_ready low 2 cycles; ALUout=42 after 3 cycles; back-to-back ADD accepted the cycle after.
REQ-034 The bench SHALL cover: BLT A=32'hFFFFFFFE (-2), B=1, PC=100, IMM=-8 -> ALUout=92, br_taken=1; BGE with the same operands -> br_taken=0.
REQ-035 The bench SHALL cover: out_ready=0 for 4 cycles after an XORI result -> ALUout/out_valid stable, in_ready=0; release -> single handshake, no duplicate.
REQ-036 The bench SHALL cover: RR opcode 001000 -> illegal=1, ALUout=0; then JUMP PC=16, IR[25:0]=26'h3FFFFFF -> ALUout=16+67108863, br_taken=1.
REQ-037 The bench SHALL cover: rst pulse one cycle into a MUL -> out_valid stays 0 after release; a subsequent SLL A=1, B=32'h21 -> ALUout=2.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Single-issue ALU with valid/ready handshakes on both sides.
//            RR/RI arithmetic, logic and shift ops complete in one cycle.
//            MUL holds the unit for MUL_LAT cycles. BRANCH produces a
//            PC-relative target plus a taken flag. JUMP produces
//            PC + zero-extended IR[25:0] with taken forced high.
//            Results are registered and held until they are consumed.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_ready   - operand bundle handshake
//            A, B, PC, IMM, IR     - operands, PC, sign-extended imm, instr
//            instr_type            - op class (000 RR, 001 RI, 100 BR,
//                                    101 JMP, 111 NOP)
//            out_valid / out_ready - result handshake
//            ALUout, br_taken, illegal - registered result fields
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] IMM,
    input  logic [31:0]     IR,
    input  logic [2:0]      instr_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUout,
    output logic            br_taken,
    output logic            illegal
);

    localparam int         c_SHW          = $clog2(XLEN);
    localparam bit         c_MUL_MULTI    = (MUL_LAT > 1);
    localparam logic [3:0] c_MUL_CNT_INIT = 4'(MUL_LAT - 1);

    // Operation classes
    localparam logic [2:0] c_T_RR  = 3'b000;
    localparam logic [2:0] c_T_RI  = 3'b001;
    localparam logic [2:0] c_T_BR  = 3'b100;
    localparam logic [2:0] c_T_JMP = 3'b101;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000001;
    localparam logic [5:0] c_OP_MUL  = 6'b000010;
    localparam logic [5:0] c_OP_AND  = 6'b000011;
    localparam logic [5:0] c_OP_OR   = 6'b000100;
    localparam logic [5:0] c_OP_XOR  = 6'b000101;
    localparam logic [5:0] c_OP_SLL  = 6'b000110;
    localparam logic [5:0] c_OP_SRL  = 6'b000111;
    localparam logic [5:0] c_OP_ADDI = 6'b001000;
    localparam logic [5:0] c_OP_SUBI = 6'b001001;
    localparam logic [5:0] c_OP_ANDI = 6'b001010;
    localparam logic [5:0] c_OP_ORI  = 6'b001011;
    localparam logic [5:0] c_OP_XORI = 6'b001100;
    localparam logic [5:0] c_OP_BEQ  = 6'b011000;
    localparam logic [5:0] c_OP_BNE  = 6'b011001;
    localparam logic [5:0] c_OP_BLT  = 6'b011010;
    localparam logic [5:0] c_OP_BGE  = 6'b011011;

    // Control states
    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_MUL_BUSY = 2'd1;
    localparam logic [1:0] c_S_HOLD     = 2'd2;

    logic [1:0]      r_state;
    logic [3:0]      r_mul_cnt;
    logic [XLEN-1:0] r_mul_a;
    logic [XLEN-1:0] r_mul_b;

    logic [5:0]      w_op;
    logic [XLEN-1:0] w_joff;
    logic [XLEN-1:0] w_res;
    logic            w_taken;
    logic            w_illegal;
    logic            w_is_mul;
    logic            w_accept;
    logic [XLEN-1:0] w_mul_res;

    assign w_op      = IR[31:26];
    assign w_joff    = XLEN'(IR[25:0]);
    assign w_mul_res = r_mul_a * r_mul_b;

    // Held low throughout reset so nothing is accepted while the unit is
    // being cleared.
    assign in_ready = !rst && (r_state == c_S_IDLE) && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Single-cycle result decode from the live operand bundle.
    always_comb begin
        w_res     = '0;
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (instr_type)
            c_T_RR: begin
                case (w_op)
                    c_OP_ADD: w_res = A + B;
                    c_OP_SUB: w_res = A - B;
                    c_OP_MUL: begin
                        w_res    = A * B;
                        w_is_mul = 1'b1;
                    end
                    c_OP_AND: w_res = A & B;
                    c_OP_OR:  w_res = A | B;
                    c_OP_XOR: w_res = A ^ B;
                    c_OP_SLL: w_res = A << B[c_SHW-1:0];
                    c_OP_SRL: w_res = A >> B[c_SHW-1:0];
                    default:  w_illegal = 1'b1;
                endcase
            end
            c_T_RI: begin
                case (w_op)
                    c_OP_ADDI: w_res = A + IMM;
                    c_OP_SUBI: w_res = A - IMM;
                    c_OP_ANDI: w_res = A & IMM;
                    c_OP_ORI:  w_res = A | IMM;
                    c_OP_XORI: w_res = A ^ IMM;
                    default:   w_illegal = 1'b1;
                endcase
            end
            c_T_BR: begin
                case (w_op)
                    c_OP_BEQ: begin
                        w_res   = PC + IMM;
                        w_taken = (A == B);
                    end
                    c_OP_BNE: begin
                        w_res   = PC + IMM;
                        w_taken = (A != B);
                    end
                    c_OP_BLT: begin
                        w_res   = PC + IMM;
                        w_taken = ($signed(A) < $signed(B));
                    end
                    c_OP_BGE: begin
                        w_res   = PC + IMM;
                        w_taken = ($signed(A) >= $signed(B));
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_T_JMP: begin
                w_res   = PC + w_joff;
                w_taken = 1'b1;
            end
            default: ;  // NOP and undefined classes yield an all-zero result
        endcase
    end

    // Control FSM and registered result. HOLD marks a result stalled by the
    // consumer; no new bundle is taken until it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_mul_cnt <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            out_valid <= 1'b0;
            ALUout    <= '0;
            br_taken  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul && c_MUL_MULTI) begin
                            // Operands are latched here so later input
                            // changes cannot leak into the product.
                            r_state   <= c_S_MUL_BUSY;
                            r_mul_cnt <= c_MUL_CNT_INIT;
                            r_mul_a   <= A;
                            r_mul_b   <= B;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            ALUout    <= w_res;
                            br_taken  <= w_taken;
                            illegal   <= w_illegal;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end else if (out_valid) begin
                        r_state <= c_S_HOLD;
                    end
                end
                c_S_MUL_BUSY: begin
                    if (r_mul_cnt <= 4'd1) begin
                        r_state   <= c_S_IDLE;
                        r_mul_cnt <= '0;
                        out_valid <= 1'b1;
                        ALUout    <= w_mul_res;
                        br_taken  <= 1'b0;
                        illegal   <= 1'b0;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - 4'd1;
                    end
                end
                c_S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench for alu_pipe. Expected results are
//            queued as bundles are accepted and compared as the unit hands
//            results over; cycle-specific behaviour is checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] IMM;
    logic [31:0]     IR;
    logic [2:0]      instr_type;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUout;
    logic            br_taken;
    logic            illegal;

    alu_pipe #(
        .XLEN    (XLEN),
        .MUL_LAT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .PC         (PC),
        .IMM        (IMM),
        .IR         (IR),
        .instr_type (instr_type),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUout     (ALUout),
        .br_taken   (br_taken),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic        tk;
        logic        il;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] opw(input logic [5:0] op);
        return {op, 26'd0};
    endfunction

    // Present a bundle, wait (bounded) for acceptance, queue its expectation.
    // Returns 1 ns after the accepting edge.
    task automatic send(input logic [2:0] t, input logic [31:0] ir, a, b, pc, imm,
                        input logic [31:0] e_alu, input logic e_tk, e_il);
        bit ok;
        ok         = 1'b0;
        instr_type = t;
        IR         = ir;
        A          = a;
        B          = b;
        PC         = pc;
        IMM        = imm;
        in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", 64'(ok), 64'd1);
        if (ok) q.push_back({e_alu, e_tk, e_il});
        else in_valid = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("sb_result", 64'({ALUout, br_taken, illegal}), 64'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        A          = '0;
        B          = '0;
        PC         = '0;
        IMM        = '0;
        IR         = '0;
        instr_type = 3'b111;

        // Reset values
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_aluout",    64'(ALUout),    64'd0);
        chk("rst_br_taken",  64'(br_taken),  64'd0);
        chk("rst_illegal",   64'(illegal),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        #8;
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ADD wrap-around, one-cycle latency
        send(3'b000, opw(6'b000000), 32'hFFFFFFFF, 32'd1, 0, 0, 32'd0, 1'b0, 1'b0);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_aluout",    64'(ALUout),    64'd0);
        chk("add_illegal",   64'(illegal),   64'd0);

        // MUL latency 3, operands captured at accept, back-to-back ADD
        send(3'b000, opw(6'b000010), 32'd7, 32'd6, 0, 0, 32'd42, 1'b0, 1'b0);
        A = 32'hDEADBEEF;
        B = 32'h12345678;
        chk("mul_busy1_in_ready",  64'(in_ready),  64'd0);
        chk("mul_busy1_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("mul_busy2_in_ready",  64'(in_ready),  64'd0);
        chk("mul_busy2_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("mul_done_out_valid", 64'(out_valid), 64'd1);
        chk("mul_done_aluout",    64'(ALUout),    64'd42);
        chk("mul_done_in_ready",  64'(in_ready),  64'd1);
        send(3'b000, opw(6'b000000), 32'd5, 32'd3, 0, 0, 32'd8, 1'b0, 1'b0);
        chk("b2b_add_out_valid", 64'(out_valid), 64'd1);
        chk("b2b_add_aluout",    64'(ALUout),    64'd8);

        // Signed branch compare
        send(3'b100, opw(6'b011010), 32'hFFFFFFFE, 32'd1, 32'd100, 32'hFFFFFFF8,
             32'd92, 1'b1, 1'b0);
        chk("blt_aluout", 64'(ALUout),   64'd92);
        chk("blt_taken",  64'(br_taken), 64'd1);
        send(3'b100, opw(6'b011011), 32'hFFFFFFFE, 32'd1, 32'd100, 32'hFFFFFFF8,
             32'd92, 1'b0, 1'b0);
        chk("bge_aluout", 64'(ALUout),   64'd92);
        chk("bge_taken",  64'(br_taken), 64'd0);
        tick();

        // Output stall: result held stable, no duplicate on release
        out_ready = 1'b0;
        send(3'b001, opw(6'b001100), 32'h0000F0F0, 32'd0, 0, 32'h00000FF0,
             32'h0000FF00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_aluout",    64'(ALUout),    64'h0000FF00);
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("release_out_valid", 64'(out_valid), 64'd0);
        tick();
        chk("release_no_dup", 64'(out_valid), 64'd0);

        // Illegal RR opcode, then JUMP with maximal offset
        send(3'b000, opw(6'b001000), 32'd9, 32'd9, 0, 0, 32'd0, 1'b0, 1'b1);
        chk("illegal_flag",   64'(illegal), 64'd1);
        chk("illegal_aluout", 64'(ALUout),  64'd0);
        send(3'b101, 32'h03FFFFFF, 0, 0, 32'd16, 0, 32'h0400000F, 1'b1, 1'b0);
        chk("jump_aluout", 64'(ALUout),   64'h0400000F);
        chk("jump_taken",  64'(br_taken), 64'd1);

        // Remaining operations, back-to-back
        send(3'b000, opw(6'b000001), 32'd5, 32'd7, 0, 0, 32'hFFFFFFFE, 1'b0, 1'b0);
        send(3'b000, opw(6'b000011), 32'hF0F0, 32'hFF00, 0, 0, 32'hF000, 1'b0, 1'b0);
        send(3'b000, opw(6'b000100), 32'hF0F0, 32'h0F0F, 0, 0, 32'hFFFF, 1'b0, 1'b0);
        send(3'b000, opw(6'b000101), 32'hAAAA, 32'hFFFF, 0, 0, 32'h5555, 1'b0, 1'b0);
        send(3'b000, opw(6'b000111), 32'h80000000, 32'h3F, 0, 0, 32'd1, 1'b0, 1'b0);
        send(3'b001, opw(6'b001000), 32'd16, 0, 0, 32'hFFFFFFFF, 32'd15, 1'b0, 1'b0);
        send(3'b001, opw(6'b001001), 32'd3, 0, 0, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
        send(3'b001, opw(6'b001010), 32'hFF, 0, 0, 32'h0F, 32'h0F, 1'b0, 1'b0);
        send(3'b001, opw(6'b001011), 32'hF0, 0, 0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        send(3'b100, opw(6'b011000), 32'd3, 32'd3, 32'd0, 32'd4, 32'd4, 1'b1, 1'b0);
        send(3'b100, opw(6'b011001), 32'd3, 32'd3, 32'd0, 32'd4, 32'd4, 1'b0, 1'b0);
        send(3'b001, opw(6'b000000), 32'd1, 32'd1, 0, 32'd1, 32'd0, 1'b0, 1'b1);
        send(3'b100, opw(6'b000000), 32'd1, 32'd1, 32'd8, 32'd1, 32'd0, 1'b0, 1'b1);
        send(3'b111, opw(6'b000000), 32'd1, 32'd1, 32'd8, 32'd1, 32'd0, 1'b0, 1'b0);
        send(3'b010, opw(6'b000000), 32'd1, 32'd1, 32'd8, 32'd1, 32'd0, 1'b0, 1'b0);

        // Reset one cycle into a MUL aborts it
        send(3'b000, opw(6'b000010), 32'd3, 32'd4, 0, 0, 32'd12, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_rst_out_valid", 64'(out_valid), 64'd0);
        chk("abort_rst_in_ready",  64'(in_ready),  64'd0);
        chk("abort_rst_aluout",    64'(ALUout),    64'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_result", 64'(out_valid), 64'd0);
        end
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        send(3'b000, opw(6'b000110), 32'd1, 32'h21, 0, 0, 32'd2, 1'b0, 1'b0);
        chk("sll_aluout", 64'(ALUout), 64'd2);

        tick();
        tick();
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
